// File: rtl/alu_pkg.sv
// ALU op dispatch package: opcode enum, unit index constants, sub-function
// encodings and decode helpers shared by the dispatcher and its scheduler.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    SLL = 4'd5,
    SRL = 4'd6,
    SRA = 4'd7
  } alu_op_e;

  // Bit positions of the units in issue_valid / en.
  localparam int UNIT_ADD   = 0;
  localparam int UNIT_BOOL  = 1;
  localparam int UNIT_SHIFT = 2;

  // Sub-function codes presented on unit_fn, interpreted per unit.
  localparam logic [1:0] FN_ADD = 2'd0;
  localparam logic [1:0] FN_SUB = 2'd1;
  localparam logic [1:0] FN_AND = 2'd0;
  localparam logic [1:0] FN_OR  = 2'd1;
  localparam logic [1:0] FN_XOR = 2'd2;
  localparam logic [1:0] FN_SLL = 2'd0;
  localparam logic [1:0] FN_SRL = 2'd1;
  localparam logic [1:0] FN_SRA = 2'd2;

  // One-hot unit for an opcode; zero for anything outside the enum.
  function automatic logic [2:0] op_to_unit(alu_op_e op);
    case (op)
      ADD, SUB:      return 3'b001;
      AND, OR, XOR:  return 3'b010;
      SLL, SRL, SRA: return 3'b100;
      default:       return 3'b000;
    endcase
  endfunction

  // Sub-function code for an opcode; don't-care (zero) for illegal codes.
  function automatic logic [1:0] op_to_fn(alu_op_e op);
    case (op)
      ADD:     return FN_ADD;
      SUB:     return FN_SUB;
      AND:     return FN_AND;
      OR:      return FN_OR;
      XOR:     return FN_XOR;
      SLL:     return FN_SLL;
      SRL:     return FN_SRL;
      SRA:     return FN_SRA;
      default: return 2'd0;
    endcase
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alu_op_dispatch_sched.sv
// Landing-slot scheduler: a pending shift register indexed by "cycles until
// the result reaches the mux". Slot 0 drives en; one cycle later the tag of
// that result is presented alongside the mux's registered output.
module alu_op_dispatch_sched
  import alu_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int ADD_LAT   = 1,
  parameter int BOOL_LAT  = 1,
  parameter int SHIFT_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       acc_unit,
  input  logic [TAG_W-1:0] acc_tag,
  output logic [2:0]       slot_free,
  output logic [2:0]       en,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag
);

  localparam int MAXL  = max3(ADD_LAT, BOOL_LAT, SHIFT_LAT);
  localparam int DEPTH = MAXL + 2;

  logic [2:0]       unit_q [DEPTH];
  logic [2:0]       unit_d [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [TAG_W-1:0] tag_d  [DEPTH];
  logic [2:0]       shift_unit [DEPTH];
  logic [TAG_W-1:0] shift_tag  [DEPTH];
  logic             res_valid_q;
  logic [TAG_W-1:0] res_tag_q;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_shift
      if (gi < DEPTH - 1) begin : g_mid
        assign shift_unit[gi] = unit_q[gi+1];
        assign shift_tag[gi]  = tag_q[gi+1];
      end else begin : g_top
        assign shift_unit[gi] = 3'b000;
        assign shift_tag[gi]  = '0;
      end
    end
  endgenerate

  // A unit's landing slot is LAT+1 now, which becomes LAT after this cycle's shift.
  assign slot_free[UNIT_ADD]   = ~|unit_q[ADD_LAT+1];
  assign slot_free[UNIT_BOOL]  = ~|unit_q[BOOL_LAT+1];
  assign slot_free[UNIT_SHIFT] = ~|unit_q[SHIFT_LAT+1];

  // Advance the pending vector and book the landing slot of an accepted op.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      unit_d[i] = shift_unit[i];
      tag_d[i]  = shift_tag[i];
    end
    if (acc_unit[UNIT_ADD]) begin
      unit_d[ADD_LAT] = 3'b001;
      tag_d[ADD_LAT]  = acc_tag;
    end
    if (acc_unit[UNIT_BOOL]) begin
      unit_d[BOOL_LAT] = 3'b010;
      tag_d[BOOL_LAT]  = acc_tag;
    end
    if (acc_unit[UNIT_SHIFT]) begin
      unit_d[SHIFT_LAT] = 3'b100;
      tag_d[SHIFT_LAT]  = acc_tag;
    end
  end

  // Pending vector and result-tag pipeline; reset discards all in-flight ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        unit_q[i] <= 3'b000;
        tag_q[i]  <= '0;
      end
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        unit_q[i] <= unit_d[i];
        tag_q[i]  <= tag_d[i];
      end
      res_valid_q <= |unit_q[0];
      if (|unit_q[0]) res_tag_q <= tag_q[0];
    end
  end

  assign en        = unit_q[0];
  assign res_valid = res_valid_q;
  assign res_tag   = res_tag_q;

endmodule

// File: rtl/alu_op_dispatch.sv
// ALU issue stage: valid/ready handshake, opcode decode, operand registers,
// and a landing-slot scheduler so the result mux never sees two results at once.
// Optional feature: define ALU_DISPATCH_ERR_EN to add the illegal_op pulse port.
module alu_op_dispatch
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 4,
  parameter int ADD_LAT   = 1,
  parameter int BOOL_LAT  = 1,
  parameter int SHIFT_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAG_W-1:0] op_tag,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic [1:0]       unit_fn,
  output logic [2:0]       issue_valid,
  output logic [2:0]       en,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag
`ifdef ALU_DISPATCH_ERR_EN
  ,
  output logic             illegal_op
`endif
);

  alu_op_e          op_e;
  logic [2:0]       op_unit;
  logic [1:0]       op_fn;
  logic             op_legal;
  logic             accept;
  logic [2:0]       acc_unit;
  logic [2:0]       slot_free;

  logic [WIDTH-1:0] unit_a_q, unit_a_d;
  logic [WIDTH-1:0] unit_b_q, unit_b_d;
  logic [1:0]       unit_fn_q, unit_fn_d;
  logic [2:0]       issue_valid_q, issue_valid_d;

  assign op_e     = alu_op_e'(op_code);
  assign op_unit  = op_to_unit(op_e);
  assign op_fn    = op_to_fn(op_e);
  assign op_legal = |op_unit;

  // Illegal codes never occupy a slot, so they are always taken.
  assign op_ready = !rst && (!op_legal || |(op_unit & slot_free));
  assign accept   = op_valid && op_ready;
  assign acc_unit = accept ? op_unit : 3'b000;

  // Load operands only on a legal accept; otherwise hold the last values.
  always_comb begin
    unit_a_d      = unit_a_q;
    unit_b_d      = unit_b_q;
    unit_fn_d     = unit_fn_q;
    issue_valid_d = acc_unit;
    if (accept && op_legal) begin
      unit_a_d  = op_a;
      unit_b_d  = op_b;
      unit_fn_d = op_fn;
    end
  end

  // Operand and issue-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_a_q      <= '0;
      unit_b_q      <= '0;
      unit_fn_q     <= 2'd0;
      issue_valid_q <= 3'b000;
    end else begin
      unit_a_q      <= unit_a_d;
      unit_b_q      <= unit_b_d;
      unit_fn_q     <= unit_fn_d;
      issue_valid_q <= issue_valid_d;
    end
  end

  assign unit_a      = unit_a_q;
  assign unit_b      = unit_b_q;
  assign unit_fn     = unit_fn_q;
  assign issue_valid = issue_valid_q;

`ifdef ALU_DISPATCH_ERR_EN
  logic illegal_q;

  // One-cycle report of an accepted illegal opcode, aligned with issue timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= accept && !op_legal;
  end

  assign illegal_op = illegal_q;
`else
  // Illegal opcodes are accepted and dropped without any report.
`endif

  alu_op_dispatch_sched #(
    .TAG_W    (TAG_W),
    .ADD_LAT  (ADD_LAT),
    .BOOL_LAT (BOOL_LAT),
    .SHIFT_LAT(SHIFT_LAT)
  ) u_sched (
    .clk      (clk),
    .rst      (rst),
    .acc_unit (acc_unit),
    .acc_tag  (op_tag),
    .slot_free(slot_free),
    .en       (en),
    .res_valid(res_valid),
    .res_tag  (res_tag)
  );

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Bench for alu_op_dispatch: directed cases plus random traffic, checked by a
// timing scoreboard built from the cycle rules (issue at T+1, en at T+1+LAT,
// result tag at T+2+LAT, one result per landing cycle).
module tb_alu_op_dispatch;

  localparam int WIDTH     = 32;
  localparam int TAG_W     = 4;
  localparam int ADD_LAT   = 1;
  localparam int BOOL_LAT  = 1;
  localparam int SHIFT_LAT = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [3:0]       op_code = 4'd0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic [TAG_W-1:0] op_tag = '0;
  logic [WIDTH-1:0] unit_a;
  logic [WIDTH-1:0] unit_b;
  logic [1:0]       unit_fn;
  logic [2:0]       issue_valid;
  logic [2:0]       en;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
`ifdef ALU_DISPATCH_ERR_EN
  logic             illegal_op;
`endif

  alu_op_dispatch #(
    .WIDTH(WIDTH), .TAG_W(TAG_W), .ADD_LAT(ADD_LAT),
    .BOOL_LAT(BOOL_LAT), .SHIFT_LAT(SHIFT_LAT)
  ) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_tag(op_tag),
    .unit_a(unit_a), .unit_b(unit_b), .unit_fn(unit_fn),
    .issue_valid(issue_valid), .en(en), .res_valid(res_valid), .res_tag(res_tag)
`ifdef ALU_DISPATCH_ERR_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int               land;
    logic [2:0]       unit;
    logic [TAG_W-1:0] tag;
  } res_t;

  typedef struct {
    int               c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       fn;
    logic [2:0]       unit;
  } iss_t;

  res_t exp_q[$];
  iss_t iss_q[$];
  bit   booked[int];
  int   ill_cyc = -100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s @cyc %0d", name, cyc);
  endtask

  // Reference rules: opcode groups, their latencies and sub-function numbering.
  function automatic int lat_of(input logic [3:0] op);
    if (op <= 4'd1) return ADD_LAT;
    if (op <= 4'd4) return BOOL_LAT;
    return SHIFT_LAT;
  endfunction

  function automatic logic [2:0] unit_of(input logic [3:0] op);
    if (op > 4'd7)  return 3'b000;
    if (op <= 4'd1) return 3'b001;
    if (op <= 4'd4) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [1:0] fn_of(input logic [3:0] op);
    case (op)
      4'd1, 4'd3, 4'd6: return 2'd1;
      4'd4, 4'd7:       return 2'd2;
      default:          return 2'd0;
    endcase
  endfunction

  // An op may go only if nothing else already lands at its result cycle.
  function automatic bit model_ready(input logic [3:0] op, input int c);
    if (op > 4'd7) return 1'b1;
    return !booked.exists(c + 1 + lat_of(op));
  endfunction

  task automatic model_clear();
    exp_q.delete();
    iss_q.delete();
    booked.delete();
    ill_cyc = -100;
  endtask

  task automatic model_accept(input logic [3:0] op, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                              input int c);
    res_t r;
    iss_t s;
    if (op > 4'd7) begin
      ill_cyc = c;
    end else begin
      r.land = c + 1 + lat_of(op);
      r.unit = unit_of(op);
      r.tag  = tag;
      booked[r.land] = 1'b1;
      exp_q.push_back(r);
      s.c = c; s.a = a; s.b = b; s.fn = fn_of(op); s.unit = unit_of(op);
      iss_q.push_back(s);
    end
  endtask

  // Offer one op starting just after a rising edge; returns its accept cycle.
  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                      output int acc_cyc);
    int  waited;
    bit  done;
    bit  exp_rdy;
    waited  = 0;
    done    = 1'b0;
    acc_cyc = -1;
    op_valid = 1'b1; op_code = op; op_a = a; op_b = b; op_tag = tag;
    while (!done) begin
      @(negedge clk);
      exp_rdy = model_ready(op, cyc);
      chk("op_ready", op_ready, exp_rdy);
      if (op_ready) begin
        model_accept(op, a, b, tag, cyc);
        acc_cyc = cyc;
        done = 1'b1;
        $display("[TB] cyc %0d accept op=%0d tag=%0d a=%0h b=%0h", cyc, op, tag, a, b);
      end
      @(posedge clk); #1;
      if (!done) begin
        waited++;
        if (waited > 20) begin
          fail_now("accept_timeout");
          done = 1'b1;
        end
      end
    end
    op_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compare every DUT output against the scoreboard each cycle.
  always @(negedge clk) begin
    int idx;
    if (rst) begin
      chk("rst_en", en, 3'b000);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_issue_valid", issue_valid, 3'b000);
      chk("rst_op_ready", op_ready, 1'b0);
      chk("rst_res_tag", res_tag, '0);
      chk("rst_unit_a", unit_a, '0);
      chk("rst_unit_b", unit_b, '0);
      chk("rst_unit_fn", unit_fn, 2'd0);
`ifdef ALU_DISPATCH_ERR_EN
      chk("rst_illegal_op", illegal_op, 1'b0);
`endif
    end else begin
      if (issue_valid != 3'b000) begin
        if (iss_q.size() == 0 || iss_q[0].c + 1 != cyc) begin
          fail_now("issue_unexpected");
        end else begin
          iss_t s;
          s = iss_q.pop_front();
          chk("issue_valid", issue_valid, s.unit);
          chk("unit_a", unit_a, s.a);
          chk("unit_b", unit_b, s.b);
          chk("unit_fn", unit_fn, s.fn);
        end
      end else if (iss_q.size() > 0 && iss_q[0].c + 1 <= cyc) begin
        fail_now("issue_missing");
        void'(iss_q.pop_front());
      end

      idx = -1;
      foreach (exp_q[i]) if (exp_q[i].land == cyc) idx = i;
      if (en != 3'b000) begin
        chk("en_onehot", $countones(en), 1);
        if (idx < 0) fail_now("en_unexpected");
        else         chk("en_unit", en, exp_q[idx].unit);
      end else if (idx >= 0) begin
        fail_now("en_missing");
      end

      idx = -1;
      foreach (exp_q[i]) if (exp_q[i].land + 1 == cyc) idx = i;
      if (res_valid) begin
        if (idx < 0) begin
          fail_now("res_unexpected");
        end else begin
          chk("res_tag", res_tag, exp_q[idx].tag);
          $display("[TB] cyc %0d result tag=%0d", cyc, res_tag);
          exp_q.delete(idx);
        end
      end else if (idx >= 0) begin
        fail_now("res_missing");
        exp_q.delete(idx);
      end

`ifdef ALU_DISPATCH_ERR_EN
      chk("illegal_op", illegal_op, (cyc == ill_cyc + 1));
`endif
    end
  end

  initial begin
    int c1, c2, prev;
    logic [3:0] op;

    // Power-up reset, then ready with nothing in flight.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    op_code = 4'd0;
    #1 chk("ready_after_rst", op_ready, 1'b1);
    idle(1);

    // Single ADD with exact cycle placement.
    send(4'd0, 32'd5, 32'd7, 4'd3, c1);
    chk("t2_issue", issue_valid, 3'b001);
    chk("t2_unit_a", unit_a, 32'd5);
    chk("t2_unit_b", unit_b, 32'd7);
    chk("t2_fn", unit_fn, 2'd0);
    idle(1);
    chk("t2_en", en, 3'b001);
    idle(1);
    chk("t2_res_valid", res_valid, 1'b1);
    chk("t2_res_tag", res_tag, 4'd3);
    idle(3);

    // Reset in the middle of idle.
    rst = 1'b1;
    model_clear();
    #1;
    chk("t1_en", en, 3'b000);
    chk("t1_res_valid", res_valid, 1'b0);
    idle(2);
    rst = 1'b0;
    #1 chk("t1_ready", op_ready, 1'b1);
    idle(1);

    // SLL then ADD: ADD must wait for a free landing cycle.
    send(4'd5, 32'h1, 32'd4, 4'd1, c1);
    send(4'd0, 32'd10, 32'd20, 4'd2, c2);
    chk("t3_add_delay", c2 - c1, 2);
    idle(6);

    // Eight back-to-back ANDs.
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      send(4'd2, $urandom, $urandom, i[TAG_W-1:0], c1);
      if (i > 0) chk("t4_b2b", c1 - prev, 1);
      prev = c1;
    end
    idle(6);

    // Two shifts in flight, reset while the first one is on the mux.
    send(4'd6, 32'hF0, 32'd2, 4'd9, c1);
    send(4'd7, 32'hF00, 32'd3, 4'd10, c2);
    idle(1);
    chk("t5_pre_rst_en", en, 3'b100);
    rst = 1'b1;
    model_clear();
    #1;
    chk("t5_en_drop", en, 3'b000);
    chk("t5_res_drop", res_valid, 1'b0);
    idle(1);
    rst = 1'b0;
    idle(6);

    // Illegal opcode.
    send(4'hF, 32'd1, 32'd2, 4'd5, c1);
    chk("t6_no_issue", issue_valid, 3'b000);
    idle(5);

    // Random traffic including illegal codes and idle gaps.
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 9));
      if (op > 4'd7) op = 4'($urandom_range(8, 15));
      send(op, $urandom, $urandom, 4'($urandom), c1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(12);

    chk("drain_results", exp_q.size(), 0);
    chk("drain_issues", iss_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout @cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
